gate_route_ctrl: RTL and testbench

Controller in front of the gate receive path that owns the per-destination routing capability table.
- Host programs or revokes capabilities through the table write port.
- Ingress requesters present route bytes; the block arbitrates round-robin, validates each route against the table and per-port in-flight credit, then issues one grant or deny at a time toward the user-logic (UL) port mux.
- Credits are returned by the UL side on completion.

---
 rtl/gate_route_ctrl_pkg.sv | 27 ++
 rtl/gate_route_ctrl_rr_arb.sv | 31 +++
 rtl/gate_route_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_gate_route_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_route_ctrl_pkg.sv
// Shared types for the gate routing controller: decision codes, table entries, route bytes.
package gate_route_ctrl_pkg;

  localparam int unsigned GATE_TAG_BITS  = 5;
  localparam int unsigned GATE_CNT_BITS  = 4;
  localparam int unsigned GATE_PORT_BITS = 2;

  typedef enum logic [1:0] {
    GATE_OK     = 2'd0,
    GATE_NOCAP  = 2'd1,
    GATE_TAGERR = 2'd2,
    GATE_BUSY   = 2'd3
  } gate_code_t;

  typedef struct packed {
    logic                     valid;
    logic [GATE_TAG_BITS-1:0] tag;
  } cap_entry_t;

  // Route byte layout: [7:3] tag, [2] reserved, [1:0] destination
  typedef struct packed {
    logic [GATE_TAG_BITS-1:0]  tag;
    logic                      rsvd;
    logic [GATE_PORT_BITS-1:0] dest;
  } route_t;

endpackage

// File: rtl/gate_route_ctrl_rr_arb.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping at N.
module gate_route_ctrl_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [2:0]   idx,
  output logic         any
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  // Scan N candidates starting at the pointer, keep the first hit
  always_comb begin
    int unsigned c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      c = (32'(ptr) + i) % N;
      if (!any && req[IW'(c)]) begin
        any           = 1'b1;
        idx           = 3'(c);
        gnt[IW'(c)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_route_ctrl.sv
// Gate routing controller: owns the capability table, arbitrates ingress route
// requests, validates them against table and per-destination credit, and issues
// one grant/deny decision at a time toward the UL port mux.
module gate_route_ctrl
  import gate_route_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned N_DESTS      = 4,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cap_wr_valid,
  output logic                 cap_wr_ready,
  input  logic [7:0]           cap_wr_data,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*8-1:0]   req_route,
  output logic                 gnt_valid,
  input  logic                 gnt_ready,
  output logic [2:0]           gnt_req,
  output logic [1:0]           gnt_port,
  output logic [1:0]           gnt_code,
  input  logic                 rel_valid,
  input  logic [1:0]           rel_port,
  output logic [N_DESTS-1:0]   cap_valid_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  logic [1:0]               state_q, state_d;
  cap_entry_t               tbl [N_DESTS];
  logic [GATE_CNT_BITS-1:0] cnt [N_DESTS];
  logic [2:0]               rr_ptr;
  logic [2:0]               req_q;
  route_t                   route_q;

  logic [N_REQ-1:0]         arb_gnt;
  logic [2:0]               arb_idx;
  logic                     arb_any;
  logic                     accept;
  route_t                   sel_route;
  gate_code_t               code_c;
  logic                     hs;
  logic [N_DESTS-1:0]       inc_vec;
  logic [N_DESTS-1:0]       dec_vec;
  logic                     unused_rsvd;

  gate_route_ctrl_rr_arb #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign unused_rsvd = route_q.rsvd;
  assign accept      = (state_q == ST_IDLE) && arb_any && cap_wr_ready;
  assign req_ready   = accept ? arb_gnt : '0;
  assign hs          = gnt_valid && gnt_ready;

  // Route byte of the requester currently being picked
  always_comb begin
    sel_route = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) sel_route = req_route[8*i +: 8];
    end
  end

  // Decision from the table and counters as they stand this cycle
  always_comb begin
    cap_entry_t               ent;
    logic [GATE_CNT_BITS-1:0] cur;
    logic                     hit;
    ent    = '0;
    cur    = '0;
    hit    = 1'b0;
    code_c = GATE_OK;
    for (int unsigned d = 0; d < N_DESTS; d++) begin
      if (route_q.dest == 2'(d)) begin
        hit = 1'b1;
        ent = tbl[d];
        cur = cnt[d];
      end
    end
    if (!hit || !ent.valid)                         code_c = GATE_NOCAP;
    else if (route_q.tag != ent.tag)                code_c = GATE_TAGERR;
    else if (cur == GATE_CNT_BITS'(MAX_INFLIGHT))   code_c = GATE_BUSY;
    else                                            code_c = GATE_OK;
  end

  // Per-destination credit take (granted handshake) and return strobes
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned d = 0; d < N_DESTS; d++) begin
      inc_vec[d] = hs && (gnt_code == GATE_OK) && (gnt_port == 2'(d));
      dec_vec[d] = rel_valid && (rel_port == 2'(d));
    end
  end

  // Status view of the table valid bits
  always_comb begin
    cap_valid_out = '0;
    for (int unsigned d = 0; d < N_DESTS; d++) cap_valid_out[d] = tbl[d].valid;
  end

  // FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept)    state_d = ST_LOOKUP;
      ST_LOOKUP:                state_d = ST_OUT;
      ST_OUT:    if (gnt_ready) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Accept latch, round-robin pointer and registered decision outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cap_wr_ready <= 1'b0;
      rr_ptr       <= '0;
      req_q        <= '0;
      route_q      <= '0;
      gnt_valid    <= 1'b0;
      gnt_req      <= '0;
      gnt_port     <= '0;
      gnt_code     <= '0;
    end else begin
      cap_wr_ready <= 1'b1;
      if (accept) begin
        req_q   <= arb_idx;
        route_q <= sel_route;
        rr_ptr  <= (32'(arb_idx) + 32'd1 >= N_REQ) ? 3'd0 : arb_idx + 3'd1;
      end
      if (state_q == ST_LOOKUP) begin
        gnt_valid <= 1'b1;
        gnt_req   <= req_q;
        gnt_port  <= route_q.dest;
        gnt_code  <= 2'(code_c);
      end else if (hs) begin
        gnt_valid <= 1'b0;
      end
    end
  end

  // Capability table; writes to nonexistent destinations fall through
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned d = 0; d < N_DESTS; d++) tbl[d] <= '0;
    end else if (cap_wr_valid) begin
      for (int unsigned d = 0; d < N_DESTS; d++) begin
        if (cap_wr_data[1:0] == 2'(d)) begin
          tbl[d].valid <= cap_wr_data[2];
          tbl[d].tag   <= cap_wr_data[7:3];
        end
      end
    end
  end

  // In-flight counters; take and return on the same edge cancel out
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned d = 0; d < N_DESTS; d++) cnt[d] <= '0;
    end else begin
      for (int unsigned d = 0; d < N_DESTS; d++) begin
        if (inc_vec[d] && !dec_vec[d])
          cnt[d] <= cnt[d] + GATE_CNT_BITS'(1);
        else if (dec_vec[d] && !inc_vec[d] && (cnt[d] != '0))
          cnt[d] <= cnt[d] - GATE_CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_gate_route_ctrl.sv
// Directed bench for gate_route_ctrl with hand-computed expected decisions.
module tb_gate_route_ctrl;

  logic        aclk;
  logic        aresetn;
  logic        cap_wr_valid;
  logic        cap_wr_ready;
  logic [7:0]  cap_wr_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_route;
  logic        gnt_valid;
  logic        gnt_ready;
  logic [2:0]  gnt_req;
  logic [1:0]  gnt_port;
  logic [1:0]  gnt_code;
  logic        rel_valid;
  logic [1:0]  rel_port;
  logic [3:0]  cap_valid_out;

  int n_vec = 0;
  int n_err = 0;

  // Route bytes {tag, rsvd, dest}
  localparam logic [7:0] R_D0  = {5'd3, 1'b0, 2'd0};
  localparam logic [7:0] R_D1  = {5'd5, 1'b0, 2'd1};
  localparam logic [7:0] R_D1B = {5'd6, 1'b0, 2'd1};
  localparam logic [7:0] R_D2  = {5'd7, 1'b0, 2'd2};
  localparam logic [7:0] R_D3  = {5'd9, 1'b0, 2'd3};

  gate_route_ctrl #(.N_REQ(4), .N_DESTS(4), .MAX_INFLIGHT(4)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cap_wr_valid  (cap_wr_valid),
    .cap_wr_ready  (cap_wr_ready),
    .cap_wr_data   (cap_wr_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_route     (req_route),
    .gnt_valid     (gnt_valid),
    .gnt_ready     (gnt_ready),
    .gnt_req       (gnt_req),
    .gnt_port      (gnt_port),
    .gnt_code      (gnt_code),
    .rel_valid     (rel_valid),
    .rel_port      (rel_port),
    .cap_valid_out (cap_valid_out)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cap_wr(input logic [1:0] d, input logic en, input logic [4:0] tag);
    @(negedge aclk);
    cap_wr_valid = 1'b1;
    cap_wr_data  = {tag, en, d};
    @(negedge aclk);
    cap_wr_valid = 1'b0;
  endtask

  task automatic rel(input logic [1:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      rel_valid = 1'b1;
      rel_port  = p;
    end
    @(negedge aclk);
    rel_valid = 1'b0;
  endtask

  // Single request from requester r; checks accept, latency and decision
  task automatic do_req(input string nm, input int r, input logic [7:0] route,
                        input logic [1:0] ecode);
    @(negedge aclk);
    req_valid[r]        = 1'b1;
    req_route[8*r +: 8] = route;
    #1 chk({nm, ".acc"}, 32'(req_ready), 32'(1) << r);
    @(negedge aclk);
    req_valid[r] = 1'b0;
    chk({nm, ".early"}, 32'(gnt_valid), 32'd0);
    @(negedge aclk);
    chk({nm, ".gv"},   32'(gnt_valid), 32'd1);
    chk({nm, ".req"},  32'(gnt_req),   32'(r));
    chk({nm, ".port"}, 32'(gnt_port),  32'(route[1:0]));
    chk({nm, ".code"}, 32'(gnt_code),  32'(ecode));
    gnt_ready = 1'b1;
    @(negedge aclk);
    gnt_ready = 1'b0;
    chk({nm, ".drop"}, 32'(gnt_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    aresetn      = 1'b0;
    cap_wr_valid = 1'b0;
    cap_wr_data  = '0;
    req_valid    = '0;
    req_route    = '0;
    gnt_ready    = 1'b0;
    rel_valid    = 1'b0;
    rel_port     = '0;

    // Reset state
    repeat (3) @(negedge aclk);
    req_valid = 4'b0001;
    #1;
    chk("rst.wr_ready", 32'(cap_wr_ready),  32'd0);
    chk("rst.req_ready", 32'(req_ready),    32'd0);
    chk("rst.gv",        32'(gnt_valid),    32'd0);
    chk("rst.gfields",   32'({gnt_req, gnt_port, gnt_code}), 32'd0);
    chk("rst.capv",      32'(cap_valid_out), 32'd0);
    req_valid = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1 chk("rel.wr_ready0", 32'(cap_wr_ready), 32'd0);
    @(negedge aclk);
    chk("rel.wr_ready1", 32'(cap_wr_ready), 32'd1);

    // Program dest 1 and grant
    cap_wr(2'd1, 1'b1, 5'd5);
    chk("cap.d1", 32'(cap_valid_out), 32'h2);
    do_req("g1", 0, R_D1, 2'd0);

    // Tag mismatch and invalid destination
    do_req("tagerr", 2, R_D1B, 2'd2);
    do_req("nocap", 3, R_D3, 2'd1);

    // Round robin with all requesters continuously valid
    cap_wr(2'd0, 1'b1, 5'd3);
    cap_wr(2'd2, 1'b1, 5'd7);
    cap_wr(2'd3, 1'b1, 5'd9);
    chk("cap.all", 32'(cap_valid_out), 32'hF);
    @(negedge aclk);
    req_route = {R_D3, R_D2, R_D1, R_D0};
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      c = 0;
      while (req_ready == '0 && c < 20) begin
        @(negedge aclk);
        c++;
      end
      chk("rr.acc", 32'(req_ready), 32'(1) << (k % 4));
      @(negedge aclk);
      c = 0;
      while (!gnt_valid && c < 20) begin
        @(negedge aclk);
        c++;
      end
      chk("rr.req",  32'(gnt_req),  32'(k % 4));
      chk("rr.code", 32'(gnt_code), 32'd0);
      gnt_ready = 1'b1;
      @(negedge aclk);
      gnt_ready = 1'b0;
      if (k == 4) req_valid = '0;
    end
    // counts now: d0=2 d1=2 d2=1 d3=1

    // Release saturates, then fill dest 0 to the limit
    rel(2'd0, 6);
    for (int k = 0; k < 4; k++) do_req("fill0", 0, R_D0, 2'd0);
    do_req("busy0", 0, R_D0, 2'd3);
    rel(2'd0, 1);
    do_req("after_rel0", 1, R_D0, 2'd0);

    // Dest 2 to inflight 2, then a held decision with same-edge release
    do_req("d2a", 2, R_D2, 2'd0);
    @(negedge aclk);
    req_valid[0]    = 1'b1;
    req_route[7:0]  = R_D2;
    #1 chk("hold.acc", 32'(req_ready), 32'd1);
    @(negedge aclk);
    req_valid[0] = 1'b0;
    @(negedge aclk);
    chk("hold.gv0", 32'(gnt_valid), 32'd1);
    req_valid[1]    = 1'b1;
    req_route[15:8] = R_D1;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      if (k == 3) begin
        cap_wr_valid = 1'b1;
        cap_wr_data  = {5'd9, 1'b0, 2'd3};
      end else begin
        cap_wr_valid = 1'b0;
      end
      chk("hold.gv",   32'(gnt_valid), 32'd1);
      chk("hold.flds", 32'({gnt_req, gnt_port, gnt_code}), 32'({3'd0, 2'd2, 2'd0}));
      chk("hold.rdy",  32'(req_ready), 32'd0);
    end
    chk("hold.revoke", 32'(cap_valid_out), 32'h7);
    req_valid[1] = 1'b0;
    gnt_ready    = 1'b1;
    rel_valid    = 1'b1;
    rel_port     = 2'd2;
    @(negedge aclk);
    gnt_ready = 1'b0;
    rel_valid = 1'b0;
    chk("hold.drop", 32'(gnt_valid), 32'd0);
    do_req("d2b", 2, R_D2, 2'd0);
    do_req("d2c", 3, R_D2, 2'd0);
    do_req("d2busy", 0, R_D2, 2'd3);
    do_req("d3revoked", 3, R_D3, 2'd1);

    // Reset while a decision is pending
    @(negedge aclk);
    req_valid[0]   = 1'b1;
    req_route[7:0] = R_D1;
    @(negedge aclk);
    req_valid[0] = 1'b0;
    @(negedge aclk);
    chk("rstout.gv1", 32'(gnt_valid), 32'd1);
    req_valid[1] = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    chk("rstout.gv",    32'(gnt_valid),     32'd0);
    chk("rstout.flds",  32'({gnt_req, gnt_port, gnt_code}), 32'd0);
    chk("rstout.capv",  32'(cap_valid_out), 32'd0);
    chk("rstout.wrrdy", 32'(cap_wr_ready),  32'd0);
    chk("rstout.rdy",   32'(req_ready),     32'd0);
    req_valid = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    do_req("post_rst", 0, R_D1, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
